// File: rtl/byte_stream_checker.sv
// Incrementing-byte stream checker: hunts for SYNC_LEN consecutive
// incrementing bytes, locks, then counts matching and mismatching bytes.
// Ports: clk, rst_n (async, active-low), din_vld/din (stream in),
//   clr (sync clear), locked, err (per-byte pulse), ok_cnt, err_cnt.
module byte_stream_checker #(
  parameter int DW       = 8,
  parameter int SYNC_LEN = 4,
  parameter int LOSS_THR = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_vld,
  input  logic [DW-1:0]    din,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] ok_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int RW = $clog2(SYNC_LEN + 1);
  localparam int MW = $clog2(LOSS_THR + 1);
  localparam logic [RW-1:0] SYNC_V = RW'(SYNC_LEN);
  localparam logic [MW-1:0] LOSS_V = MW'(LOSS_THR);

  typedef enum logic {
    HUNT,
    LOCK
  } state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    exp_q, exp_d;
  logic [RW-1:0]    run_q, run_d;
  logic [MW-1:0]    miss_q, miss_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] ok_q, ok_d;
  logic [CNT_W-1:0] errc_q, errc_d;

  logic             hit;
  logic [RW-1:0]    run_inc;
  logic [MW-1:0]    miss_inc;

  assign hit      = (din == exp_q);
  assign miss_inc = miss_q + MW'(1);

  // A mismatching byte in HUNT begins a fresh run of length one.
  always_comb begin
    run_inc = RW'(1);
    if (run_q != '0 && hit) begin
      run_inc = run_q + RW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    run_d   = run_q;
    miss_d  = miss_q;
    err_d   = 1'b0;
    ok_d    = ok_q;
    errc_d  = errc_q;
    if (clr) begin
      state_d = HUNT;
      run_d   = '0;
      miss_d  = '0;
      ok_d    = '0;
      errc_d  = '0;
    end else if (din_vld) begin
      case (state_q)
        HUNT: begin
          exp_d = din + DW'(1);
          run_d = run_inc;
          if (run_inc == SYNC_V) begin
            state_d = LOCK;
            run_d   = '0;
            miss_d  = '0;
          end
        end
        default: begin
          // Freewheel so one corrupted byte costs exactly one error.
          exp_d = exp_q + DW'(1);
          if (hit) begin
            miss_d = '0;
            if (ok_q != '1) begin
              ok_d = ok_q + CNT_W'(1);
            end
          end else begin
            err_d  = 1'b1;
            miss_d = miss_inc;
            if (errc_q != '1) begin
              errc_d = errc_q + CNT_W'(1);
            end
            if (miss_inc == LOSS_V) begin
              state_d = HUNT;
              run_d   = '0;
              miss_d  = '0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      exp_q   <= '0;
      run_q   <= '0;
      miss_q  <= '0;
      err_q   <= 1'b0;
      ok_q    <= '0;
      errc_q  <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      run_q   <= run_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
      ok_q    <= ok_d;
      errc_q  <= errc_d;
    end
  end

  assign locked  = (state_q == LOCK);
  assign err     = err_q;
  assign ok_cnt  = ok_q;
  assign err_cnt = errc_q;

endmodule
